payment_unit: RTL and testbench
===============================

Name: payment_unit

Overview:
- Upstream credit/payment stage for the vending controller.
- Accepts coins while a product is selected, accumulates credit against the selected item's price and pulses `paid` when credit covers the price, with change.
- Generates the controller's `timeOut` input and answers its `cancelled` request with a refund and a `cancelledDone` handshake.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles in COLLECT without a coin before `timeOut` asserts.
- CREDIT_W, 8: width of credit, price, change and refund values, in units of 5 cents.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- state  in  2  current vending state; 00 select, 01 product available/pay, 11 cancel.
- index  in  4  selected item index, latched into `item_latched` on entry to COLLECT.
- price  in  CREDIT_W  price of the selected item, sampled every cycle in COLLECT.
- coin_valid  in  1  one-cycle strobe, coin inserted.
- coin_value  in  2  coin code; 0=1, 1=2, 2=5, 3=20 units.
- cancelled  in  1  cancel request level from the state controller.
- credit  out  CREDIT_W  current accumulated credit.
- item_latched  out  4  index captured at first coin.
- paid  out  1  one-cycle pulse, purchase complete.
- change_valid  out  1  one-cycle pulse, coincident with `paid`.
- change_amount  out  CREDIT_W  equals credit−price; valid only with `change_valid`.
- refund_valid  out  1  one-cycle pulse on refund.
- refund_amount  out  CREDIT_W  refunded credit; valid only with `refund_valid`.
- coin_reject  out  1  one-cycle pulse, coin not accepted (returned).
- timeOut  out  1  level, payment timed out.
- cancelledDone  out  1  level, refund finished.

Behaviour:
- Reset (synchronous, active-high) values:
  - FSM goes to IDLE.
  - Zeroed: credit, item_latched, change_amount, refund_amount, timer.
  - Deasserted: all pulses, timeOut, cancelledDone.
- Reset mid-operation discards credit silently; no refund pulse is produced.
- FSM states are IDLE, COLLECT, REFUND, DONE_WAIT.
- IDLE:
  - coin_valid with state==01: credit ← coin units, item_latched ← index, timer ← 0, go to COLLECT.
  - coin_valid with any other state: coin_reject pulse next cycle, stay in IDLE.
  - cancelled=1 in IDLE: go to DONE_WAIT with refund_amount=0 and no refund_valid pulse.
- COLLECT, evaluated each cycle in this priority order:
  1. cancelled=1 → REFUND. A coin in the same cycle is rejected (coin_reject).
  2. credit ≥ price, using registered credit → next cycle:
     - paid=1, change_valid=1, change_amount=credit−price;
     - credit ← 0, timer ← 0, go to IDLE.
     - A coin in the same cycle is rejected.
  3. coin_valid:
     - credit ← credit+units, timer ← 0.
     - If the sum exceeds 2^CREDIT_W−1, the coin is rejected instead and credit is unchanged.
     - A coin and timer expiry in the same cycle: the coin wins and the timer reloads.
  4. Otherwise timer increments, saturating. At timer == TIMEOUT_CYCLES−1, timeOut ← 1.
- Payment latency: credit reaching price on cycle N gives paid on cycle N+2. Credit is registered at N+1; the compare happens at N+1 and the pulse at N+2.
- timeOut stays high until the FSM leaves COLLECT, then clears.
- price changes mid-COLLECT are honoured on the next compare.
- REFUND, single cycle:
  - refund_valid=1, refund_amount=credit;
  - credit ← 0, timeOut ← 0, cancelledDone ← 1;
  - go to DONE_WAIT.
- DONE_WAIT:
  - Holds cancelledDone=1 until cancelled=0.
  - Then cancelledDone ← 0 on the next edge, go to IDLE.
  - Coins in this state are rejected.
- Pulse outputs are registered and last exactly one cycle. Amount outputs hold their last value otherwise.

Test Plan:
- Exact payment:
  - Stimulus: reset 2 cycles, state=01, price=10, index=3; coins 5,5 (code 2,2).
  - Response: credit 5→10, item_latched=3, paid=1 with change_amount=0 two cycles after the 2nd coin, credit→0.
- Overpay:
  - Stimulus: price=7, coin 20 (code 3).
  - Response: paid=1, change_valid=1, change_amount=13, one cycle each.
- Timeout/cancel:
  - Stimulus: TIMEOUT_CYCLES=8, coin 2 then none.
  - Response: timeOut=1 eight cycles after the coin.
  - Then cancelled=1 → refund_valid=1, refund_amount=2, cancelledDone=1.
  - Drop cancelled → cancelledDone=0 next cycle, FSM in IDLE.
- Simultaneous events:
  - Stimulus: coin on the same cycle as cancelled=1 in COLLECT.
  - Response: coin_reject=1, refund_amount excludes that coin.
  - Coin arriving exactly at timer expiry → credit increases, timeOut stays 0.
- Overflow/reject:
  - Stimulus: credit=250, price=255, coin 20.
  - Response: coin_reject=1, credit stays 250.
  - Coin with state=00 in IDLE → coin_reject=1, credit=0.
- Reset mid-operation:
  - Stimulus: reset asserted with credit=15 in COLLECT.
  - Response: next cycle credit=0, no refund_valid/paid pulse, all outputs at reset values.

Source files
------------

// File: rtl/payment_unit.sv
// Credit/payment stage ahead of the vending controller: collects coins, pays out
// with change, generates timeOut and services cancel requests with a refund.
module payment_unit #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CREDIT_W       = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          state,
   input  logic [3:0]          index,
   input  logic [CREDIT_W-1:0] price,
   input  logic                coin_valid,
   input  logic [1:0]          coin_value,
   input  logic                cancelled,
   output logic [CREDIT_W-1:0] credit,
   output logic [3:0]          item_latched,
   output logic                paid,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amount,
   output logic                refund_valid,
   output logic [CREDIT_W-1:0] refund_amount,
   output logic                coin_reject,
   output logic                timeOut,
   output logic                cancelledDone,
   output logic [1:0]          fsm_state
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COLLECT   = 2'd1,
      REFUND    = 2'd2,
      DONE_WAIT = 2'd3
   } st_t;

   st_t                cur_st, nxt_st;
   logic [TW-1:0]      timer, timer_d;
   logic [CREDIT_W-1:0] credit_d, change_d, refund_d, units;
   logic [3:0]         item_d;
   logic               paid_d, refund_valid_d, reject_d, timeout_d, done_d;
   logic [CREDIT_W:0]  sum;

   assign fsm_state = cur_st;

   always_comb begin
      units = '0;
      case (coin_value)
         2'd0: units = CREDIT_W'(1);
         2'd1: units = CREDIT_W'(2);
         2'd2: units = CREDIT_W'(5);
         default: units = CREDIT_W'(20);
      endcase
   end

   // One extra bit so a coin that would wrap the credit can be detected and rejected.
   assign sum = {1'b0, credit} + {1'b0, units};

   always_comb begin
      nxt_st         = cur_st;
      credit_d       = credit;
      item_d         = item_latched;
      timer_d        = timer;
      paid_d         = 1'b0;
      change_d       = change_amount;
      refund_valid_d = 1'b0;
      refund_d       = refund_amount;
      reject_d       = 1'b0;
      timeout_d      = timeOut;
      done_d         = cancelledDone;
      case (cur_st)
         IDLE: begin
            if (cancelled) begin
               reject_d = coin_valid;
               refund_d = '0;
               done_d   = 1'b1;
               nxt_st   = DONE_WAIT;
            end else if (coin_valid) begin
               if (state == 2'b01) begin
                  credit_d = units;
                  item_d   = index;
                  timer_d  = '0;
                  nxt_st   = COLLECT;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (cancelled) begin
               reject_d = coin_valid;
               nxt_st   = REFUND;
            end else if (credit >= price) begin
               reject_d = coin_valid;
               paid_d   = 1'b1;
               change_d = credit - price;
               credit_d = '0;
               timer_d  = '0;
               nxt_st   = IDLE;
            end else if (coin_valid) begin
               timer_d = '0;
               if (sum[CREDIT_W]) reject_d = 1'b1;
               else               credit_d = sum[CREDIT_W-1:0];
            end else begin
               if (timer != T_MAX) timer_d = timer + 1'b1;
               if (timer == T_MAX) timeout_d = 1'b1;
            end
         end
         REFUND: begin
            reject_d       = coin_valid;
            refund_valid_d = 1'b1;
            refund_d       = credit;
            credit_d       = '0;
            done_d         = 1'b1;
            nxt_st         = DONE_WAIT;
         end
         default: begin
            reject_d = coin_valid;
            if (!cancelled) begin
               done_d = 1'b0;
               nxt_st = IDLE;
            end
         end
      endcase
      // timeOut only has meaning while collecting.
      if (nxt_st != COLLECT) timeout_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_st        <= IDLE;
         credit        <= '0;
         item_latched  <= '0;
         timer         <= '0;
         paid          <= 1'b0;
         change_valid  <= 1'b0;
         change_amount <= '0;
         refund_valid  <= 1'b0;
         refund_amount <= '0;
         coin_reject   <= 1'b0;
         timeOut       <= 1'b0;
         cancelledDone <= 1'b0;
      end else begin
         cur_st        <= nxt_st;
         credit        <= credit_d;
         item_latched  <= item_d;
         timer         <= timer_d;
         paid          <= paid_d;
         change_valid  <= paid_d;
         change_amount <= change_d;
         refund_valid  <= refund_valid_d;
         refund_amount <= refund_d;
         coin_reject   <= reject_d;
         timeOut       <= timeout_d;
         cancelledDone <= done_d;
      end
   end

endmodule

// File: tb/tb_payment_unit.sv
// Self-checking bench for payment_unit: directed scenarios with a scoreboard of
// expected pulse events (paid/refund/reject) popped as the DUT emits them.
module tb_payment_unit;

   localparam int W = 8;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   state;
   logic [3:0]   index;
   logic [W-1:0] price;
   logic         coin_valid;
   logic [1:0]   coin_value;
   logic         cancelled;
   logic [W-1:0] credit, change_amount, refund_amount;
   logic [3:0]   item_latched;
   logic         paid, change_valid, refund_valid, coin_reject, timeOut, cancelledDone;
   logic [1:0]   fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Event word: [10:8] kind (1 paid, 2 refund, 3 reject), [7:0] amount.
   logic [10:0] exp_q[$];

   payment_unit #(.TIMEOUT_CYCLES(TO), .CREDIT_W(W)) dut (
      .clk(clk), .reset(reset), .state(state), .index(index), .price(price),
      .coin_valid(coin_valid), .coin_value(coin_value), .cancelled(cancelled),
      .credit(credit), .item_latched(item_latched), .paid(paid),
      .change_valid(change_valid), .change_amount(change_amount),
      .refund_valid(refund_valid), .refund_amount(refund_amount),
      .coin_reject(coin_reject), .timeOut(timeOut), .cancelledDone(cancelledDone),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input logic [1:0] code);
      coin_valid = 1'b1;
      coin_value = code;
      step();
      coin_valid = 1'b0;
   endtask

   task automatic score(input logic [10:0] obs);
      if (exp_q.size() == 0) check("unexpected_event", 32'(obs), 32'h7ff);
      else check("event", 32'(obs), 32'(exp_q.pop_front()));
   endtask

   always @(negedge clk) begin
      if (paid) begin
         check("change_valid_with_paid", 32'(change_valid), 32'd1);
         score({3'd1, change_amount});
      end
      if (refund_valid) score({3'd2, refund_amount});
      if (coin_reject)  score({3'd3, 8'd0});
   end

   initial begin
      reset = 1'b1; state = 2'b00; index = '0; price = '0;
      coin_valid = 1'b0; coin_value = '0; cancelled = 1'b0;

      // Reset state
      step(); step();
      reset = 1'b0;
      check("rst_credit", 32'(credit), 0);
      check("rst_item", 32'(item_latched), 0);
      check("rst_timeout", 32'(timeOut), 0);
      check("rst_done", 32'(cancelledDone), 0);
      check("rst_fsm", 32'(fsm_state), 0);

      // Exact payment
      state = 2'b01; price = 8'd10; index = 4'd3;
      coin(2'd2);
      check("exact_credit5", 32'(credit), 5);
      check("exact_item", 32'(item_latched), 3);
      exp_q.push_back({3'd1, 8'd0});
      coin(2'd2);
      check("exact_credit10", 32'(credit), 10);
      check("exact_no_early_paid", 32'(paid), 0);
      step();
      check("exact_paid", 32'(paid), 1);
      check("exact_change", 32'(change_amount), 0);
      check("exact_credit0", 32'(credit), 0);

      // Overpay
      price = 8'd7;
      exp_q.push_back({3'd1, 8'd13});
      coin(2'd3);
      check("over_credit", 32'(credit), 20);
      step();
      check("over_paid", 32'(paid), 1);
      check("over_change", 32'(change_amount), 13);
      step();
      check("over_paid_one_cycle", 32'(paid), 0);
      check("over_cv_one_cycle", 32'(change_valid), 0);

      // Timeout then cancel
      price = 8'd20;
      coin(2'd1);
      for (int i = 0; i < TO - 1; i++) step();
      check("to_not_yet", 32'(timeOut), 0);
      step();
      check("to_asserted", 32'(timeOut), 1);
      cancelled = 1'b1;
      exp_q.push_back({3'd2, 8'd2});
      step(); step();
      check("to_refund_valid", 32'(refund_valid), 1);
      check("to_refund_amt", 32'(refund_amount), 2);
      check("to_done", 32'(cancelledDone), 1);
      check("to_credit0", 32'(credit), 0);
      check("to_timeout_clr", 32'(timeOut), 0);
      step(); step();
      check("to_done_hold", 32'(cancelledDone), 1);
      cancelled = 1'b0;
      step();
      check("to_done_clr", 32'(cancelledDone), 0);
      check("to_fsm_idle", 32'(fsm_state), 0);

      // Coin on the same cycle as cancel
      price = 8'd50;
      coin(2'd2);
      cancelled = 1'b1;
      exp_q.push_back({3'd3, 8'd0});
      exp_q.push_back({3'd2, 8'd5});
      coin(2'd3);
      check("sim_reject", 32'(coin_reject), 1);
      step();
      check("sim_refund_amt", 32'(refund_amount), 5);
      cancelled = 1'b0;
      step();

      // Coin exactly at timer expiry
      coin(2'd1);
      for (int i = 0; i < TO - 1; i++) step();
      coin(2'd1);
      check("expiry_credit", 32'(credit), 4);
      check("expiry_timeout", 32'(timeOut), 0);
      step();
      check("expiry_timeout_after", 32'(timeOut), 0);
      cancelled = 1'b1;
      exp_q.push_back({3'd2, 8'd4});
      step(); step();
      cancelled = 1'b0;
      step();

      // Overflow reject
      price = 8'd255;
      for (int i = 0; i < 12; i++) coin(2'd3);
      coin(2'd2); coin(2'd2);
      check("ovf_credit250", 32'(credit), 250);
      exp_q.push_back({3'd3, 8'd0});
      coin(2'd3);
      check("ovf_reject", 32'(coin_reject), 1);
      check("ovf_credit_hold", 32'(credit), 250);
      cancelled = 1'b1;
      exp_q.push_back({3'd2, 8'd250});
      step(); step();
      cancelled = 1'b0;
      step();

      // Coin in IDLE with wrong vending state
      state = 2'b00;
      exp_q.push_back({3'd3, 8'd0});
      coin(2'd2);
      check("idle_reject", 32'(coin_reject), 1);
      check("idle_credit0", 32'(credit), 0);
      check("idle_fsm", 32'(fsm_state), 0);

      // Cancel from IDLE: done without refund pulse
      cancelled = 1'b1;
      step();
      check("idle_cancel_done", 32'(cancelledDone), 1);
      check("idle_cancel_no_refund", 32'(refund_valid), 0);
      check("idle_cancel_amt0", 32'(refund_amount), 0);
      cancelled = 1'b0;
      step();

      // Reset mid-operation
      state = 2'b01; price = 8'd100; index = 4'd9;
      coin(2'd2); coin(2'd2); coin(2'd2);
      check("mid_credit15", 32'(credit), 15);
      reset = 1'b1;
      step();
      check("mid_rst_credit", 32'(credit), 0);
      check("mid_rst_item", 32'(item_latched), 0);
      check("mid_rst_refund", 32'(refund_valid), 0);
      check("mid_rst_paid", 32'(paid), 0);
      check("mid_rst_fsm", 32'(fsm_state), 0);
      reset = 1'b0;
      step(); step();

      check("queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
